// File: rtl/hsci_rx_word_align_if.sv
// hsci_rx_word_align_if
//   Byte stream bundle around the HSCI MISO word aligner.
//   in_valid / in_data   : unaligned PHY byte (bit 7 earliest) and its qualifier
//   out_valid / out_data : byte-aligned MISO byte (bit 7 earliest) and its qualifier
//   master : the side that drives PHY data and receives aligned data
//   slave  : the aligner itself
interface hsci_rx_word_align_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/hsci_rx_word_align.sv
// hsci_rx_word_align
//   Per-lane HSCI MISO word aligner in the hsci_pclk domain. Searches the 16-bit history window
//   for the SYNC byte at bit offsets 0..7, qualifies the offset over LOCK_CNT consecutive hits,
//   then emits byte-aligned data. Sustained slip (SYNC seen only at some other offset for
//   UNLOCK_CNT slip cycles) drops lock so the link layer can re-train.
// Ports
//   hsci_pclk   : PHY parallel clock, the only clock
//   hsci_rstn   : asynchronous active-low reset
//   bus         : in_valid/in_data from the PHY, out_valid/out_data aligned output
//   stat_clr    : synchronous clear of the statistics counters
//   locked      : high while aligned output is being produced
//   bit_offset  : selected offset k, meaningful in VERIFY and LOCKED
//   lock_loss   : LOCKED->SEARCH event count
//   verify_fail : VERIFY->SEARCH event count
// Configuration
//   HSCI_RX_ALIGN_STATS_EN : when defined, lock_loss/verify_fail are saturating 16-bit counters
//   cleared by stat_clr; otherwise they are tied to zero and stat_clr is ignored.
module hsci_rx_word_align #(
  parameter logic [7:0]  SYNC_PATTERN = 8'hA5,
  parameter int unsigned LOCK_CNT     = 4,
  parameter int unsigned UNLOCK_CNT   = 8
) (
  input  logic                 hsci_pclk,
  input  logic                 hsci_rstn,
  hsci_rx_word_align_if.slave  bus,
  input  logic                 stat_clr,
  output logic                 locked,
  output logic [2:0]           bit_offset,
  output logic [15:0]          lock_loss,
  output logic [15:0]          verify_fail
);

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  state_e      state_q, state_d;
  logic [15:0] win_q, win_d;
  logic [2:0]  off_q, off_d;
  logic [3:0]  hit_q, hit_d;
  logic [7:0]  slip_q, slip_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        locked_q;
  logic        ev_lock_loss, ev_verify_fail;

  logic [7:0]  cand [8];
  logic [7:0]  match;
  logic [2:0]  first_k;
  logic        other_match;

  // Candidates come from the window registered in the previous valid cycle.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      cand[k]  = win_q[15-k -: 8];
      match[k] = (cand[k] == SYNC_PATTERN);
    end
    first_k = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (match[k]) first_k = 3'(k);
    end
    other_match = |(match & ~(8'b1 << off_q));
  end

  always_comb begin
    state_d        = state_q;
    win_d          = win_q;
    off_d          = off_q;
    hit_d          = hit_q;
    slip_d         = slip_q;
    out_data_d     = out_data_q;
    out_valid_d    = 1'b0;
    ev_lock_loss   = 1'b0;
    ev_verify_fail = 1'b0;
    if (bus.in_valid) begin
      win_d = {win_q[7:0], bus.in_data};
      case (state_q)
        StSearch: begin
          if (|match) begin
            off_d   = first_k;
            hit_d   = 4'd1;
            state_d = (LOCK_CNT == 1) ? StLocked : StVerify;
          end
        end
        StVerify: begin
          if (match[off_q]) begin
            hit_d = hit_q + 4'd1;
            if (hit_q == 4'(LOCK_CNT - 1)) state_d = StLocked;
          end else begin
            state_d        = StSearch;
            hit_d          = 4'd0;
            ev_verify_fail = 1'b1;
          end
        end
        StLocked: begin
          // The cycle that leaves LOCKED still delivers its byte.
          out_data_d  = cand[off_q];
          out_valid_d = 1'b1;
          if (match[off_q]) begin
            slip_d = 8'd0;
          end else if (other_match) begin
            if (slip_q == 8'(UNLOCK_CNT - 1)) begin
              state_d      = StSearch;
              slip_d       = 8'd0;
              ev_lock_loss = 1'b1;
            end else begin
              slip_d = slip_q + 8'd1;
            end
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  always_ff @(posedge hsci_pclk or negedge hsci_rstn) begin
    if (!hsci_rstn) begin
      state_q     <= StSearch;
      win_q       <= 16'h0;
      off_q       <= 3'd0;
      hit_q       <= 4'd0;
      slip_q      <= 8'd0;
      out_data_q  <= 8'h0;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      off_q       <= off_d;
      hit_q       <= hit_d;
      slip_q      <= slip_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      // Delayed one cycle so locked brackets exactly the out_valid cycles.
      locked_q    <= (state_q == StLocked);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign locked        = locked_q;
  assign bit_offset    = off_q;

`ifdef HSCI_RX_ALIGN_STATS_EN
  logic [15:0] lock_loss_q, verify_fail_q;

  always_ff @(posedge hsci_pclk or negedge hsci_rstn) begin
    if (!hsci_rstn) begin
      lock_loss_q   <= 16'h0;
      verify_fail_q <= 16'h0;
    end else if (stat_clr) begin
      lock_loss_q   <= 16'h0;
      verify_fail_q <= 16'h0;
    end else begin
      if (ev_lock_loss && (lock_loss_q != 16'hFFFF))     lock_loss_q   <= lock_loss_q + 16'd1;
      if (ev_verify_fail && (verify_fail_q != 16'hFFFF)) verify_fail_q <= verify_fail_q + 16'd1;
    end
  end

  assign lock_loss   = lock_loss_q;
  assign verify_fail = verify_fail_q;
`else
  logic unused_stats;
  assign unused_stats = stat_clr ^ ev_lock_loss ^ ev_verify_fail;
  assign lock_loss    = 16'h0;
  assign verify_fail  = 16'h0;
`endif

endmodule
